// File: rtl/game_ctrl_pkg.sv
// Shared game constants, state codes and coordinate helpers for game_ctrl.
package game_ctrl_pkg;

  // State codes kept numerically identical to the legacy encodings used by
  // the pipe generator and the overlay.
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] PLAY = 2'd1;
  localparam logic [1:0] DEAD = 2'd2;

  localparam int unsigned SCREEN_W = 640;
  localparam int unsigned SCREEN_H = 480;

  // Collision arithmetic is done 11 bits wide so sums of 10-bit columns and
  // sprite sizes never wrap.
  localparam int unsigned COORD_W = 11;
  typedef logic [COORD_W-1:0] coord_t;

  // Zero-extend a 10-bit column into the collision domain.
  function automatic coord_t col_ext(input logic [9:0] v);
    return coord_t'(v);
  endfunction

  // Zero-extend a 9-bit row into the collision domain.
  function automatic coord_t row_ext(input logic [8:0] v);
    return coord_t'(v);
  endfunction

endpackage

// File: rtl/game_ctrl_bcd2_counter.sv
// Two-digit BCD score counter: sync clear, +1/+2 steps, saturates at 99.
module bcd2_counter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       inc1,
  input  logic       inc2,
  output logic [7:0] bcd
);

  logic [3:0] ones;
  logic [3:0] tens;
  logic [1:0] amount;
  logic [4:0] ones_sum;

  // Step size for this cycle; inc2 covers two pipes passed on one tick.
  always_comb begin
    amount = 2'd0;
    if (inc2)
      amount = 2'd2;
    else if (inc1)
      amount = 2'd1;
    ones_sum = {1'b0, ones} + {3'b000, amount};
  end

  // Digit update with carry into tens and saturation at 99.
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      ones <= '0;
      tens <= '0;
    end else if (amount != 2'd0) begin
      if (ones_sum > 5'd9) begin
        if (tens == 4'd9) begin
          ones <= 4'd9;
        end else begin
          ones <= 4'(ones_sum - 5'd10);
          tens <= tens + 4'd1;
        end
      end else begin
        ones <= ones_sum[3:0];
      end
    end
  end

  assign bcd = {tens, ones};

endmodule

// File: rtl/game_ctrl.sv
// Game-state controller: collision detection, pipe scoring and run FSM.
module game_ctrl
  import game_ctrl_pkg::*;
#(
  parameter int unsigned BIRD_W    = 48,
  parameter int unsigned BIRD_H    = 34,
  parameter int unsigned PIPE_W    = 52,
  parameter int unsigned GAP_H     = 120,
  parameter int unsigned GROUND_Y  = 400,
  parameter int unsigned DEAD_HOLD = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic       start_btn,
  input  logic [9:0] bird_x,
  input  logic [8:0] bird_y,
  input  logic [9:0] pipe0_x,
  input  logic [8:0] pipe0_gap,
  input  logic [9:0] pipe1_x,
  input  logic [8:0] pipe1_gap,
  output logic       playing,
  output logic       game_over,
  output logic       hit,
  output logic [7:0] score_bcd
);

  localparam coord_t C_BIRD_W   = coord_t'(BIRD_W);
  localparam coord_t C_BIRD_H   = coord_t'(BIRD_H);
  localparam coord_t C_PIPE_W   = coord_t'(PIPE_W);
  localparam coord_t C_GAP_H    = coord_t'(GAP_H);
  localparam coord_t C_GROUND_Y = coord_t'(GROUND_Y);
  localparam coord_t C_SCREEN_H = coord_t'(SCREEN_H);

  localparam int unsigned HOLD_W = $clog2(DEAD_HOLD + 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(DEAD_HOLD);

  logic [1:0]        state;
  logic              start_q;
  logic [HOLD_W-1:0] hold_cnt;
  logic [1:0]        passed;

  coord_t bx;
  coord_t by;
  coord_t px [2];
  coord_t pg [2];

  logic [1:0] pipe_hit;
  logic [1:0] pipe_pass;
  logic [1:0] pipe_respawn;
  logic       ceiling_hit;
  logic       ground_hit;
  logic       collide;
  logic       eval;
  logic       score_tick;
  logic       start_edge;
  logic       go_play;
  logic       inc1;
  logic       inc2;

  // Widen all positions into the non-wrapping collision domain.
  always_comb begin
    bx    = col_ext(bird_x);
    by    = row_ext(bird_y);
    px[0] = col_ext(pipe0_x);
    px[1] = col_ext(pipe1_x);
    pg[0] = row_ext(pipe0_gap);
    pg[1] = row_ext(pipe1_gap);
  end

  // Per-pipe overlap, pass and respawn terms for the current inputs.
  always_comb begin
    pipe_hit     = '0;
    pipe_pass    = '0;
    pipe_respawn = '0;
    for (int unsigned k = 0; k < 2; k++) begin
      pipe_hit[k] = (bx < px[k] + C_PIPE_W) && (bx + C_BIRD_W > px[k]) &&
                    ((by < pg[k]) || (by + C_BIRD_H > pg[k] + C_GAP_H));
      pipe_pass[k]    = !passed[k] && (px[k] + C_PIPE_W <= bx);
      pipe_respawn[k] = px[k] > bx + C_BIRD_W;
    end
  end

  // Screen-edge collisions, evaluation qualifiers and run-start decision.
  always_comb begin
    ceiling_hit = by >= C_SCREEN_H;
    ground_hit  = by + C_BIRD_H > C_GROUND_Y;
    collide     = ceiling_hit || ground_hit || (|pipe_hit);
    eval        = (state == PLAY) && frame_tick;
    score_tick  = eval && !collide;
    start_edge  = start_btn && !start_q;
    go_play     = start_edge &&
                  ((state == IDLE) || ((state == DEAD) && (hold_cnt == HOLD_MAX)));
    inc1        = score_tick && (pipe_pass == 2'b01 || pipe_pass == 2'b10);
    inc2        = score_tick && (pipe_pass == 2'b11);
  end

  // Run FSM, hit pulse and start-button edge register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      hit     <= 1'b0;
      start_q <= 1'b0;
    end else begin
      start_q <= start_btn;
      hit     <= eval && collide;
      case (state)
        IDLE:    if (go_play) state <= PLAY;
        PLAY:    if (eval && collide) state <= DEAD;
        DEAD:    if (go_play) state <= PLAY;
        default: state <= IDLE;
      endcase
    end
  end

  // Frames spent in DEAD, saturating once restart becomes allowed.
  always_ff @(posedge clk) begin
    if (!rst_n || go_play || (eval && collide)) begin
      hold_cnt <= '0;
    end else if ((state == DEAD) && frame_tick && (hold_cnt != HOLD_MAX)) begin
      hold_cnt <= hold_cnt + 1'b1;
    end
  end

  // Passed flags: set on first pass, cleared once the pipe reappears on the right.
  always_ff @(posedge clk) begin
    if (!rst_n || go_play) begin
      passed <= '0;
    end else if (score_tick) begin
      for (int unsigned k = 0; k < 2; k++) begin
        if (pipe_pass[k])
          passed[k] <= 1'b1;
        else if (pipe_respawn[k])
          passed[k] <= 1'b0;
      end
    end
  end

  bcd2_counter u_score (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (go_play),
    .inc1  (inc1),
    .inc2  (inc2),
    .bcd   (score_bcd)
  );

  assign playing   = (state == PLAY);
  assign game_over = (state == DEAD);

endmodule

// File: tb/tb_game_ctrl.sv
// Self-checking bench for game_ctrl: directed scenarios plus random stimulus
// against a behavioural game model.
module tb_game_ctrl;

  logic       clk;
  logic       rst_n;
  logic       frame_tick;
  logic       start_btn;
  logic [9:0] bird_x;
  logic [8:0] bird_y;
  logic [9:0] pipe0_x;
  logic [8:0] pipe0_gap;
  logic [9:0] pipe1_x;
  logic [8:0] pipe1_gap;
  logic       playing;
  logic       game_over;
  logic       hit;
  logic [7:0] score_bcd;

  game_ctrl #(
    .BIRD_W    (48),
    .BIRD_H    (34),
    .PIPE_W    (52),
    .GAP_H     (120),
    .GROUND_Y  (400),
    .DEAD_HOLD (32)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .frame_tick (frame_tick),
    .start_btn  (start_btn),
    .bird_x     (bird_x),
    .bird_y     (bird_y),
    .pipe0_x    (pipe0_x),
    .pipe0_gap  (pipe0_gap),
    .pipe1_x    (pipe1_x),
    .pipe1_gap  (pipe1_gap),
    .playing    (playing),
    .game_over  (game_over),
    .hit        (hit),
    .score_bcd  (score_bcd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model: game mode, integer score, passed flags, frames dead.
  localparam int M_IDLE = 0;
  localparam int M_PLAY = 1;
  localparam int M_DEAD = 2;

  int m_mode   = M_IDLE;
  int m_score  = 0;
  int m_hold   = 0;
  bit m_prev   = 1'b0;
  bit m_hit    = 1'b0;
  bit m_passed [2] = '{1'b0, 1'b0};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int to_bcd(input int s);
    return ((s / 10) << 4) | (s % 10);
  endfunction

  function automatic bit collides(input int bx, input int by,
                                  input int p0x, input int p0g,
                                  input int p1x, input int p1g);
    int xs [2];
    int gs [2];
    bit c;
    xs[0] = p0x; xs[1] = p1x;
    gs[0] = p0g; gs[1] = p1g;
    c = (by >= 480) || (by + 34 > 400);
    for (int k = 0; k < 2; k++)
      if (bx < xs[k] + 52 && bx + 48 > xs[k] && (by < gs[k] || by + 34 > gs[k] + 120))
        c = 1'b1;
    return c;
  endfunction

  // Advance the model by one clock using the inputs present at the edge.
  task automatic model_edge();
    bit edge_s;
    int gained;
    int bx, by;
    int xs [2];
    bx = int'(bird_x);
    by = int'(bird_y);
    xs[0] = int'(pipe0_x);
    xs[1] = int'(pipe1_x);
    if (!rst_n) begin
      m_mode = M_IDLE; m_score = 0; m_hold = 0; m_prev = 1'b0; m_hit = 1'b0;
      m_passed[0] = 1'b0; m_passed[1] = 1'b0;
      return;
    end
    edge_s = start_btn && !m_prev;
    m_prev = start_btn;
    m_hit  = 1'b0;
    case (m_mode)
      M_IDLE: begin
        if (edge_s) begin
          m_mode = M_PLAY; m_score = 0;
          m_passed[0] = 1'b0; m_passed[1] = 1'b0;
        end
      end
      M_PLAY: begin
        if (frame_tick) begin
          if (collides(bx, by, xs[0], int'(pipe0_gap), xs[1], int'(pipe1_gap))) begin
            m_mode = M_DEAD; m_hold = 0; m_hit = 1'b1;
          end else begin
            gained = 0;
            for (int k = 0; k < 2; k++) begin
              if (!m_passed[k] && xs[k] + 52 <= bx) begin
                gained++;
                m_passed[k] = 1'b1;
              end else if (xs[k] > bx + 48) begin
                m_passed[k] = 1'b0;
              end
            end
            m_score = (m_score + gained > 99) ? 99 : m_score + gained;
          end
        end
      end
      default: begin
        if (edge_s && m_hold >= 32) begin
          m_mode = M_PLAY; m_score = 0;
          m_passed[0] = 1'b0; m_passed[1] = 1'b0;
        end else if (frame_tick && m_hold < 32) begin
          m_hold++;
        end
      end
    endcase
  endtask

  // One clock: model follows the edge, outputs are compared 1 time unit later.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("playing",   playing,   (m_mode == M_PLAY));
    check("game_over", game_over, (m_mode == M_DEAD));
    check("hit",       hit,       m_hit);
    check("score",     score_bcd, to_bcd(m_score));
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
  endtask

  task automatic press();
    start_btn = 1'b1;
    step();
    start_btn = 1'b0;
    step();
  endtask

  task automatic set_safe();
    bird_x = 10'd35;  bird_y = 9'd160;
    pipe0_x = 10'd600; pipe0_gap = 9'd150;
    pipe1_x = 10'd900; pipe1_gap = 9'd150;
  endtask

  task automatic restart();
    set_safe();
    repeat (32) tick();
    press();
    check("restart_playing", playing, 1'b1);
  endtask

  initial begin
    rst_n = 1'b0; frame_tick = 1'b0; start_btn = 1'b0;
    set_safe();
    step(); step();
    check("rst_playing", playing, 1'b0);
    check("rst_over",    game_over, 1'b0);
    check("rst_score",   score_bcd, 8'h00);
    rst_n = 1'b1;
    step();

    // Start edge
    start_btn = 1'b1; step();
    check("start_playing", playing, 1'b1);
    check("start_score",   score_bcd, 8'h00);
    check("start_over",    game_over, 1'b0);
    start_btn = 1'b0; step();

    // Non-colliding positions
    bird_y = 9'd0; tick();
    check("top_row_safe", playing, 1'b1);
    bird_y = 9'd160; pipe0_x = 10'd60; tick();
    check("in_gap_safe", hit, 1'b0);
    pipe0_x = 10'd83; bird_y = 9'd140; tick();
    check("x_edge_safe", playing, 1'b1);

    // Scoring
    bird_x = 10'd200; bird_y = 9'd160; pipe0_x = 10'd148; tick();
    check("pass_once", score_bcd, 8'h01);
    tick();
    check("pass_no_repeat", score_bcd, 8'h01);
    pipe0_x = 10'd600; tick();
    pipe0_x = 10'd148; tick();
    check("pass_again", score_bcd, 8'h02);
    repeat (96) begin
      pipe0_x = 10'd600; tick();
      pipe0_x = 10'd148; tick();
    end
    check("score_98", score_bcd, 8'h98);
    pipe0_x = 10'd600; pipe1_x = 10'd600; tick();
    pipe0_x = 10'd148; pipe1_x = 10'd148; tick();
    check("double_sat", score_bcd, 8'h99);
    pipe0_x = 10'd600; pipe1_x = 10'd600; tick();
    pipe0_x = 10'd148; tick();
    check("stay_99", score_bcd, 8'h99);

    // Pipe collision
    bird_x = 10'd35; pipe0_x = 10'd60; pipe1_x = 10'd900; bird_y = 9'd140; tick();
    check("pipe_hit",      hit, 1'b1);
    check("pipe_over",     game_over, 1'b1);
    check("pipe_playing",  playing, 1'b0);
    check("dead_score",    score_bcd, 8'h99);
    step();
    check("hit_one_clk", hit, 1'b0);

    // Start ignored during hold
    set_safe();
    repeat (31) tick();
    press();
    check("hold_ignored", game_over, 1'b1);
    tick();
    press();
    check("hold_done_play", playing, 1'b1);
    check("hold_done_score", score_bcd, 8'h00);

    // Ground and ceiling
    bird_y = 9'd380; tick();
    check("ground_hit", hit, 1'b1);
    restart();
    bird_y = 9'd500; tick();
    check("ceiling_hit", hit, 1'b1);
    restart();

    // Collision beats pass on the same tick
    bird_x = 10'd200; pipe0_x = 10'd148; bird_y = 9'd380; tick();
    check("col_wins_hit", hit, 1'b1);
    check("col_wins_score", score_bcd, 8'h00);
    restart();

    // Reset mid-run
    rst_n = 1'b0; bird_y = 9'd380; frame_tick = 1'b1; step();
    check("midrst_hit", hit, 1'b0);
    check("midrst_playing", playing, 1'b0);
    frame_tick = 1'b0; rst_n = 1'b1; step();

    // Start and tick together in IDLE
    start_btn = 1'b1; frame_tick = 1'b1; step();
    check("idle_tick_play", playing, 1'b1);
    check("idle_tick_nohit", hit, 1'b0);
    start_btn = 1'b0; frame_tick = 1'b0; set_safe(); step();

    // Random phase
    for (int i = 0; i < 4000; i++) begin
      rst_n      = ($urandom_range(0, 399) != 0);
      frame_tick = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 5) == 0) start_btn = ~start_btn;
      bird_x = 10'($urandom_range(0, 400));
      if ($urandom_range(0, 99) < 85)
        bird_y = 9'($urandom_range(60, 340));
      else
        bird_y = 9'($urandom_range(0, 511));
      pipe0_x   = 10'($urandom_range(0, 1023));
      pipe1_x   = 10'($urandom_range(0, 1023));
      pipe0_gap = 9'($urandom_range(40, 300));
      pipe1_gap = 9'($urandom_range(40, 300));
      step();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
